// File: rtl/exp5_mostra_sequencia.sv
// Memory-game sequence playback: walks the ROM from address 0 to a captured
// last address, showing each entry on the LEDs for a lit time then a dark gap.
module exp5_mostra_sequencia #(
  parameter int unsigned ON_CYCLES  = 3000,
  parameter int unsigned OFF_CYCLES = 1000,
  parameter int unsigned CW         = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] rom_data,
  output logic [3:0] rom_addr,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado,
  output logic [3:0] db_endereco
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_BUSCA   = 4'd1;
  localparam logic [3:0] S_ACESO   = 4'd2;
  localparam logic [3:0] S_APAGADO = 4'd3;
  localparam logic [3:0] S_FIM     = 4'd4;

  logic [3:0]    estado;
  logic [3:0]    estado_prox;
  logic [3:0]    lim_r;
  logic [CW-1:0] timer;
  logic          fim_aceso;
  logic          fim_apagado;
  logic          ultimo;

  assign fim_aceso   = (timer == CW'(ON_CYCLES - 1));
  assign fim_apagado = (timer == CW'(OFF_CYCLES - 1));
  assign ultimo      = (rom_addr == lim_r);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= S_IDLE;
    else        estado <= estado_prox;
  end

  // Next-state logic; unused codes fall back to IDLE
  always_comb begin
    estado_prox = S_IDLE;
    case (estado)
      S_IDLE:    estado_prox = iniciar ? S_BUSCA : S_IDLE;
      S_BUSCA:   estado_prox = S_ACESO;
      S_ACESO:   estado_prox = fim_aceso ? S_APAGADO : S_ACESO;
      S_APAGADO: begin
        if (!fim_apagado) estado_prox = S_APAGADO;
        else if (ultimo)  estado_prox = S_FIM;
        else              estado_prox = S_BUSCA;
      end
      S_FIM:     estado_prox = S_IDLE;
      default:   estado_prox = S_IDLE;
    endcase
  end

  // Address, limit capture and phase timer; address only moves on BUSCA entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rom_addr <= 4'd0;
      lim_r    <= 4'd0;
      timer    <= '0;
    end else begin
      case (estado)
        S_IDLE: begin
          if (iniciar) begin
            rom_addr <= 4'd0;
            lim_r    <= limite;
            timer    <= '0;
          end
        end
        S_BUSCA: timer <= '0;
        S_ACESO: timer <= fim_aceso ? '0 : timer + CW'(1);
        S_APAGADO: begin
          if (fim_apagado) begin
            timer <= '0;
            if (!ultimo) rom_addr <= rom_addr + 4'd1;
          end else begin
            timer <= timer + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    leds        = 4'd0;
    ocupado     = 1'b0;
    pronto      = 1'b0;
    db_estado   = estado;
    db_endereco = rom_addr;
    case (estado)
      S_BUSCA:   ocupado = 1'b1;
      S_ACESO: begin
        ocupado = 1'b1;
        leds    = rom_data;
      end
      S_APAGADO: ocupado = 1'b1;
      S_FIM: begin
        ocupado = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
